// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU sequencing datapath.
package alu_pkg;
   localparam int W    = 4;
   localparam int REGS = 4;
   localparam int AW   = 2;

   localparam logic [3:0] OP_TRANSFER   = 4'h0;
   localparam logic [3:0] OP_INC        = 4'h1;
   localparam logic [3:0] OP_ADD        = 4'h2;
   localparam logic [3:0] OP_ADDC       = 4'h3;
   localparam logic [3:0] OP_SUBB       = 4'h4;
   localparam logic [3:0] OP_SUB        = 4'h5;
   localparam logic [3:0] OP_DEC        = 4'h6;
   localparam logic [3:0] OP_TRANSFER_C = 4'h7;
   localparam logic [3:0] OP_AND        = 4'h8;
   localparam logic [3:0] OP_OR         = 4'h9;
   localparam logic [3:0] OP_XOR        = 4'hA;
   localparam logic [3:0] OP_NOT        = 4'hB;
   localparam logic [3:0] OP_LOADI      = 4'hC;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   typedef struct packed {
      logic [3:0]    op;
      logic [AW-1:0] rd;
      logic [W-1:0]  imm;
   } instr_t;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_LOADI;
   endfunction
endpackage

// File: rtl/lab5_1.sv
// 4-bit ALU: select[3]=0 is arithmetic x + B(select[2:1]) + select[0]; select[3]=1 is logic.
module lab5_1 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic [3:0] select,
   output logic [3:0] out,
   output logic       c_out
);
   logic [3:0] b;
   logic [4:0] sum;

   always_comb begin
      b = 4'h0;
      case (select[2:1])
         2'b00:   b = 4'h0;
         2'b01:   b = y;
         2'b10:   b = ~y;
         default: b = 4'hF;
      endcase
      sum   = {1'b0, x} + {1'b0, b} + {4'b0, select[0]};
      out   = sum[3:0];
      c_out = sum[4];
      if (select[3]) begin
         c_out = 1'b0;
         case (select[1:0])
            2'b00:   out = x & y;
            2'b01:   out = x | y;
            2'b10:   out = x ^ y;
            default: out = ~x;
         endcase
      end
   end
endmodule

// File: rtl/regfile4x4.sv
// 4x4 register file: one sync write port, two read ports, combinational debug read.
module regfile4x4 import alu_pkg::*; (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] ra_addr,
   output logic [W-1:0]  ra_data,
   input  logic [AW-1:0] rb_addr,
   output logic [W-1:0]  rb_data,
   input  logic [AW-1:0] dbg_addr,
   output logic [W-1:0]  dbg_data
);
   logic [W-1:0] rf [REGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < REGS; i++) rf[i] <= '0;
      end else if (we) begin
         rf[waddr] <= wdata;
      end
   end

   assign ra_data  = rf[ra_addr];
   assign rb_data  = rf[rb_addr];
   assign dbg_data = rf[dbg_addr];
endmodule

// File: rtl/alu_op_sequencer.sv
// IDLE->EXEC->WB sequencer: latches operands into ALU drive registers, writes result back.
module alu_op_sequencer import alu_pkg::*; (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_op,
   input  logic [AW-1:0] in_rd,
   input  logic [AW-1:0] in_ra,
   input  logic [AW-1:0] in_rb,
   input  logic [W-1:0]  in_imm,
   output logic [W-1:0]  alu_x,
   output logic [W-1:0]  alu_y,
   output logic [3:0]    alu_select,
   input  logic [W-1:0]  alu_out,
   input  logic          alu_c_out,
   output logic          done,
   output logic          err,
   output logic          flag_c,
   output logic          flag_z,
   input  logic [AW-1:0] dbg_addr,
   output logic [W-1:0]  dbg_data
);
   state_t       state, state_nxt;
   instr_t       ins_q;
   logic         rf_we;
   logic [W-1:0] rf_wdata, ra_data, rb_data;

   assign rf_wdata = (ins_q.op == OP_LOADI) ? ins_q.imm : alu_out;

   regfile4x4 u_rf (
      .clk     (clk),
      .reset   (reset),
      .we      (rf_we),
      .waddr   (ins_q.rd),
      .wdata   (rf_wdata),
      .ra_addr (in_ra),
      .ra_data (ra_data),
      .rb_addr (in_rb),
      .rb_data (rb_data),
      .dbg_addr(dbg_addr),
      .dbg_data(dbg_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         ins_q      <= '0;
         alu_x      <= '0;
         alu_y      <= '0;
         alu_select <= '0;
         flag_c     <= 1'b0;
         flag_z     <= 1'b0;
      end else begin
         state <= state_nxt;
         // Operands are captured at acceptance so a write to rd==ra/rb cannot disturb them.
         if (state == S_IDLE && in_valid) begin
            ins_q      <= '{op: in_op, rd: in_rd, imm: in_imm};
            alu_x      <= ra_data;
            alu_y      <= rb_data;
            alu_select <= in_op;
         end
         if (state == S_EXEC && op_legal(ins_q.op)) begin
            flag_z <= (rf_wdata == '0);
            if (!ins_q.op[3]) flag_c <= alu_c_out;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      rf_we     = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = S_EXEC;
         end
         S_EXEC: begin
            rf_we     = op_legal(ins_q.op);
            state_nxt = S_WB;
         end
         S_WB: begin
            done      = 1'b1;
            err       = !op_legal(ins_q.op);
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end
endmodule
